// File: rtl/ls_result_buffer_pkg.sv
// ---------------------------------------------------------------------------
// ls_result_buffer_pkg
//   Shared definitions for the load/store result buffer:
//     - LS_RRN_WIDTH / LS_ARN_WIDTH : default rename-tag and arch-register widths
//     - cdb_entry_t                 : one queued result / one CDB beat
//     - ls_buf_state_e              : bus-request FSM states
// ---------------------------------------------------------------------------
package ls_result_buffer_pkg;

    localparam int unsigned LS_DATA_WIDTH = 32;
    localparam int unsigned LS_RRN_WIDTH  = 6;
    localparam int unsigned LS_ARN_WIDTH  = 5;

    typedef struct packed {
        logic [LS_DATA_WIDTH-1:0] result;
        logic [LS_RRN_WIDTH-1:0]  rrn;
        logic [LS_ARN_WIDTH-1:0]  arn;
        logic                     reg_write;
    } cdb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2
    } ls_buf_state_e;

endpackage

// File: rtl/ls_result_buffer_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with synchronous active-low reset and synchronous flush.
//   Read data is the current head (combinational from storage); a pop
//   advances the head at the clock edge.
//
//   Ports:
//     clk_i    in   clock
//     rst_ni   in   synchronous active-low reset
//     flush_i  in   synchronous clear of pointers and count
//     push_i   in   write wdata_i at the tail (ignored when full)
//     wdata_i  in   WIDTH-bit write data
//     pop_i    in   drop the head entry (ignored when empty)
//     rdata_o  out  WIDTH-bit head entry
//     count_o  out  number of valid entries (log2(DEPTH)+1 bits)
//     full_o   out  count == DEPTH
//     empty_o  out  count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ls_result_buffer.sv
// ---------------------------------------------------------------------------
// ls_result_buffer
//   Queues completed load/store results and delivers them on the common data
//   bus. Each entry requests the bus (REQ), and on grant is copied into the
//   CDB output registers and driven for one cycle (DRIVE). o_ready throttles
//   the reservation-station issue path.
//
//   Handshakes:
//     upstream  : an entry is accepted on a cycle with i_valid && o_ready;
//                 o_ready depends only on registered occupancy and i_flush,
//                 so a pop in the same cycle never frees room for that push.
//     arbiter   : o_get_bus is held while in REQ; i_bus_granted is only
//                 looked at in REQ; the beat follows one cycle after grant.
//
//   Ports:
//     i_clock, i_reset_n         clock, synchronous active-low reset
//     i_flush                    synchronous pipeline clear
//     i_valid, i_result, i_rrn,
//     i_arn, i_reg_write         incoming LoadStore result
//     o_ready                    buffer can accept an entry this cycle
//     o_get_bus, i_bus_granted   CDB request / grant
//     o_cdb_valid, o_cdb_result,
//     o_cdb_rrn, o_cdb_arn,
//     o_cdb_reg_write            registered CDB beat
//
//   RRN_WIDTH / ARN_WIDTH must equal the package widths, since entries are
//   stored as cdb_entry_t.
// ---------------------------------------------------------------------------
module ls_result_buffer
    import ls_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RRN_WIDTH = LS_RRN_WIDTH,
    parameter int unsigned ARN_WIDTH = LS_ARN_WIDTH
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [31:0]          i_result,
    input  logic [RRN_WIDTH-1:0] i_rrn,
    input  logic [ARN_WIDTH-1:0] i_arn,
    input  logic                 i_reg_write,
    output logic                 o_ready,
    output logic                 o_get_bus,
    input  logic                 i_bus_granted,
    output logic                 o_cdb_valid,
    output logic [31:0]          o_cdb_result,
    output logic [RRN_WIDTH-1:0] o_cdb_rrn,
    output logic [ARN_WIDTH-1:0] o_cdb_arn,
    output logic                 o_cdb_reg_write
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    ls_buf_state_e    state_q, state_d;
    cdb_entry_t       cdb_q, cdb_d;
    cdb_entry_t       push_entry;
    cdb_entry_t       head_entry;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign o_ready = !fifo_full && !i_flush;
    assign push    = i_valid && o_ready;
    assign pop     = (state_q == DRIVE) && !i_flush;

    assign push_entry = '{result: i_result, rrn: i_rrn, arn: i_arn, reg_write: i_reg_write};

    sync_fifo #(
        .WIDTH ($bits(cdb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clock),
        .rst_ni  (i_reset_n),
        .flush_i (i_flush),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cdb_d       = cdb_q;
        o_get_bus   = 1'b0;
        o_cdb_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                o_get_bus = 1'b1;
                if (i_bus_granted) begin
                    cdb_d   = head_entry;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                o_cdb_valid = 1'b1;
                cdb_d       = '0;
                // Entries left after this pop: (count - 1 + push), non-negative here.
                if ((count > ONE_C) || push) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cdb_d   = '0;
            end
        endcase
        // Flush wins over everything: drop the request, suppress a beat in
        // flight and discard whatever would have been latched.
        if (i_flush) begin
            state_d     = IDLE;
            cdb_d       = '0;
            o_get_bus   = 1'b0;
            o_cdb_valid = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cdb_q   <= '0;
        end else begin
            state_q <= state_d;
            cdb_q   <= cdb_d;
        end
    end

    assign o_cdb_result    = cdb_q.result;
    assign o_cdb_rrn       = cdb_q.rrn;
    assign o_cdb_arn       = cdb_q.arn;
    assign o_cdb_reg_write = cdb_q.reg_write;

endmodule

// File: tb/tb_ls_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_ls_result_buffer
//   Self-checking bench for ls_result_buffer: hand-written vector tables,
//   directed multi-cycle sequences and a randomized run, all compared each
//   cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ls_result_buffer;
    import ls_result_buffer_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic        i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_result = '0;
    logic [5:0]  i_rrn = '0;
    logic [4:0]  i_arn = '0;
    logic        i_reg_write = 1'b0;
    logic        o_ready;
    logic        o_get_bus;
    logic        i_bus_granted = 1'b0;
    logic        o_cdb_valid;
    logic [31:0] o_cdb_result;
    logic [5:0]  o_cdb_rrn;
    logic [4:0]  o_cdb_arn;
    logic        o_cdb_reg_write;

    ls_result_buffer #(
        .DEPTH     (DEPTH),
        .RRN_WIDTH (6),
        .ARN_WIDTH (5)
    ) dut (
        .i_clock         (i_clock),
        .i_reset_n       (i_reset_n),
        .i_flush         (i_flush),
        .i_valid         (i_valid),
        .i_result        (i_result),
        .i_rrn           (i_rrn),
        .i_arn           (i_arn),
        .i_reg_write     (i_reg_write),
        .o_ready         (o_ready),
        .o_get_bus       (o_get_bus),
        .i_bus_granted   (i_bus_granted),
        .o_cdb_valid     (o_cdb_valid),
        .o_cdb_result    (o_cdb_result),
        .o_cdb_rrn       (o_cdb_rrn),
        .o_cdb_arn       (o_cdb_arn),
        .o_cdb_reg_write (o_cdb_reg_write)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];     // results expected on the CDB, in order
    logic [31:0] obs_q[$];     // results actually seen on the CDB

    // Reference model: pending results in arrival order plus whether the
    // buffer is currently asking for the bus or presenting a beat.
    cdb_entry_t  mq[$];
    bit          m_req = 1'b0;
    bit          m_drv = 1'b0;

    typedef struct {
        logic       ready;
        logic       get_bus;
        logic       cdb_valid;
        cdb_entry_t cdb;
    } obs_t;

    typedef struct {
        logic       v;
        cdb_entry_t e;
        logic       g;
        logic       ex_ready;
        logic       ex_get;
        logic       ex_val;
        cdb_entry_t ex_e;
    } vec_t;

    vec_t vt[$];

    function automatic cdb_entry_t ent(input logic [31:0] res, input logic [5:0] rrn,
                                       input logic [4:0] arn, input logic rw);
        cdb_entry_t r;
        r.result    = res;
        r.rrn       = rrn;
        r.arn       = arn;
        r.reg_write = rw;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Drives inputs, samples outputs 1 time unit later, compares them with the
    // model, then steps both DUT and model across the rising edge.
    task automatic run_cycle(input logic v, input cdb_entry_t e, input logic g,
                             input logic f, input logic r, output obs_t o);
        cdb_entry_t exp_e;
        logic       exp_ready;
        logic       exp_get;
        logic       exp_val;
        bit         acc;
        i_valid       = v;
        i_result      = e.result;
        i_rrn         = e.rrn;
        i_arn         = e.arn;
        i_reg_write   = e.reg_write;
        i_bus_granted = g;
        i_flush       = f;
        i_reset_n     = r;
        #1;
        o.ready     = o_ready;
        o.get_bus   = o_get_bus;
        o.cdb_valid = o_cdb_valid;
        o.cdb       = ent(o_cdb_result, o_cdb_rrn, o_cdb_arn, o_cdb_reg_write);

        exp_ready = (mq.size() < DEPTH) && !f;
        exp_get   = m_req && !f;
        exp_val   = m_drv && !f;
        exp_e     = (m_drv && mq.size() > 0) ? mq[0] : '0;
        if (r) begin
            check("ready",         32'(o.ready),         32'(exp_ready));
            check("get_bus",       32'(o.get_bus),       32'(exp_get));
            check("cdb_valid",     32'(o.cdb_valid),     32'(exp_val));
            check("cdb_result",    o.cdb.result,         exp_e.result);
            check("cdb_rrn",       32'(o.cdb.rrn),       32'(exp_e.rrn));
            check("cdb_arn",       32'(o.cdb.arn),       32'(exp_e.arn));
            check("cdb_reg_write", 32'(o.cdb.reg_write), 32'(exp_e.reg_write));
        end
        if (o.cdb_valid === 1'b1) obs_q.push_back(o.cdb.result);

        @(posedge i_clock);
        if (!r || f) begin
            mq.delete();
            m_req = 1'b0;
            m_drv = 1'b0;
        end else begin
            acc = v && exp_ready;
            if (m_drv) begin
                void'(mq.pop_front());
                m_drv = 1'b0;
                m_req = (mq.size() + int'(acc)) > 0;
            end else if (m_req) begin
                if (g) begin
                    m_req = 1'b0;
                    m_drv = 1'b1;
                end
            end else begin
                m_req = (mq.size() > 0) || acc;
            end
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    task automatic add_vec(input logic v, input cdb_entry_t e, input logic g,
                           input logic er, input logic eg, input logic ev, input cdb_entry_t ee);
        vec_t x;
        x.v = v; x.e = e; x.g = g;
        x.ex_ready = er; x.ex_get = eg; x.ex_val = ev; x.ex_e = ee;
        vt.push_back(x);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        obs_t       o;
        cdb_entry_t z;
        cdb_entry_t s;
        cdb_entry_t ef[1:5];
        int         nobs;
        int         k;
        int         budget;

        z = '0;

        // Reset held 3 cycles with i_valid high: nothing may be queued.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, ent(32'h1111_1111, 6'h1, 5'h1, 1'b1), 1'b1, 1'b0, 1'b0, o);
        run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
        check("rst_ready",   32'(o.ready),     32'd1);
        check("rst_get_bus", 32'(o.get_bus),   32'd0);
        check("rst_valid",   32'(o.cdb_valid), 32'd0);
        check("rst_result",  o.cdb.result,     32'd0);
        for (int i = 0; i < 2; i++) begin
            run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
            check("rst_nothing_queued", 32'(o.get_bus), 32'd0);
        end

        // Single entry, then fill/back-pressure: hand-derived vectors.
        s = ent(32'hDEADBEEF, 6'h12, 5'd3, 1'b1);
        for (int i = 1; i <= 5; i++) ef[i] = ent(32'hA000_0000 + 32'(i), 6'(i), 5'(i), 1'(i % 2));

        add_vec(1, s, 1, 1, 0, 0, z);
        add_vec(0, z, 1, 1, 1, 0, z);
        add_vec(0, z, 1, 1, 0, 1, s);
        add_vec(0, z, 1, 1, 0, 0, z);

        add_vec(1, ef[1], 0, 1, 0, 0, z);
        add_vec(1, ef[2], 0, 1, 1, 0, z);
        add_vec(1, ef[3], 0, 1, 1, 0, z);
        add_vec(1, ef[4], 0, 1, 1, 0, z);
        add_vec(1, ef[5], 0, 0, 1, 0, z);   // full: 5th entry ignored
        add_vec(0, z,     1, 0, 1, 0, z);
        add_vec(0, z,     1, 0, 0, 1, ef[1]);
        add_vec(0, z,     1, 1, 1, 0, z);   // room again after first pop
        add_vec(0, z,     1, 1, 0, 1, ef[2]);
        add_vec(0, z,     1, 1, 1, 0, z);
        add_vec(0, z,     1, 1, 0, 1, ef[3]);
        add_vec(0, z,     1, 1, 1, 0, z);
        add_vec(0, z,     1, 1, 0, 1, ef[4]);
        add_vec(0, z,     1, 1, 0, 0, z);
        add_vec(0, z,     1, 1, 0, 0, z);

        for (int i = 0; i < vt.size(); i++) begin
            run_cycle(vt[i].v, vt[i].e, vt[i].g, 1'b0, 1'b1, o);
            check("tbl_ready",   32'(o.ready),         32'(vt[i].ex_ready));
            check("tbl_get_bus", 32'(o.get_bus),       32'(vt[i].ex_get));
            check("tbl_valid",   32'(o.cdb_valid),     32'(vt[i].ex_val));
            check("tbl_result",  o.cdb.result,         vt[i].ex_e.result);
            check("tbl_rrn",     32'(o.cdb.rrn),       32'(vt[i].ex_e.rrn));
            check("tbl_arn",     32'(o.cdb.arn),       32'(vt[i].ex_e.arn));
            check("tbl_rw",      32'(o.cdb.reg_write), 32'(vt[i].ex_e.reg_write));
        end

        // Delayed grant: 10 cycles in REQ without grant, grant in cycle 11.
        run_cycle(1'b1, ent(32'h0000_BEEF, 6'h2A, 5'd7, 1'b0), 1'b0, 1'b0, 1'b1, o);
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, z, 1'b0, 1'b0, 1'b1, o);
            check("dly_get_bus", 32'(o.get_bus),   32'd1);
            check("dly_no_beat", 32'(o.cdb_valid), 32'd0);
        end
        run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
        check("dly_grant_cycle", 32'(o.cdb_valid), 32'd0);
        run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
        check("dly_beat_valid",  32'(o.cdb_valid), 32'd1);
        check("dly_beat_result", o.cdb.result,     32'h0000_BEEF);
        run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);

        // Flush in the first DRIVE cycle with three entries queued.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, ent(32'hF000_0000 + 32'(i), 6'(i), 5'(i), 1'b1), 1'b0, 1'b0, 1'b1, o);
        run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
        nobs = obs_q.size();
        run_cycle(1'b1, ent(32'hBAD0_0000, 6'h3F, 5'h1F, 1'b1), 1'b1, 1'b1, 1'b1, o);
        check("flush_beat_suppressed", 32'(o.cdb_valid), 32'd0);
        check("flush_ready_low",       32'(o.ready),     32'd0);
        check("flush_get_bus_low",     32'(o.get_bus),   32'd0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
            check("flush_idle_get_bus", 32'(o.get_bus),   32'd0);
            check("flush_idle_valid",   32'(o.cdb_valid), 32'd0);
        end
        check("flush_no_beats", 32'(obs_q.size()), 32'(nobs));

        // Pointer wrap: values 1..9 streamed with a grant every REQ.
        obs_q.delete();
        exp_q.delete();
        k = 1;
        budget = 0;
        while ((k <= 9 || mq.size() > 0 || m_req || m_drv) && budget < 200) begin
            if (k <= 9 && mq.size() < DEPTH) begin
                exp_q.push_back(32'(k));
                run_cycle(1'b1, ent(32'(k), 6'(k), 5'(k), 1'(k % 2)), 1'b1, 1'b0, 1'b1, o);
                k++;
            end else begin
                run_cycle(1'b0, z, 1'b1, 1'b0, 1'b1, o);
            end
            budget++;
        end
        check("wrap_within_budget", 32'(budget < 200), 32'd1);
        check("wrap_beat_count", 32'(obs_q.size()), 32'd9);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check("wrap_order", obs_q.pop_front(), exp_q.pop_front());
        end

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            run_cycle(1'($urandom_range(0, 1)),
                      ent($urandom, 6'($urandom), 5'($urandom), 1'($urandom)),
                      1'($urandom_range(0, 9) < 6),
                      1'($urandom_range(0, 99) < 3),
                      1'($urandom_range(0, 199) != 0),
                      o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
